// File: rtl/apb_spi_read_handler_if.sv
// APB bus signals shared by the SPI IO-register read path and its master.
interface apb_spi_read_handler_if;
    logic        IO_reg;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PRDATA;
    logic        PREADY_R;
    logic        PSLVERR_R;

    modport master (
        output IO_reg, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY_R, PSLVERR_R
    );

    modport slave (
        input  IO_reg, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY_R, PSLVERR_R
    );
endinterface

// File: rtl/apb_spi_read_handler.sv
// APB read-path responder for the SPI IO register: buffers received SPI words and
// answers reads, requesting a transfer and waiting (with timeout) when the FIFO is empty.
module apb_spi_read_handler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_spi_read_handler_if.slave   apb,
    input  logic                    SPI_rx_valid,
    input  logic [15:0]             SPI_rx_data,
    output logic                    SPI_recv,
    output logic [$clog2(DEPTH):0]  RX_level,
    output logic                    RX_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel  = (AW + 1)'(DEPTH);
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   prdata_q, prdata_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic          recv_q, recv_d;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;

    logic rd_acc, fifo_empty, fifo_full, push, pop;

    assign rd_acc     = apb.IO_reg & apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullLevel);
    // A full FIFO still accepts a word when the head is popped in the same cycle.
    assign push       = SPI_rx_valid & (~fifo_full | pop);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        recv_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (rd_acc) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        prdata_d = mem_q[rd_ptr_q];
                        pready_d = 1'b1;
                        state_d  = StResp;
                    end else begin
                        recv_d  = 1'b1;
                        cnt_d   = 16'd1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!rd_acc) begin
                    state_d = StIdle;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    prdata_d = mem_q[rd_ptr_q];
                    pready_d = 1'b1;
                    state_d  = StResp;
                end else if (cnt_q == TimeoutCnt) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            recv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            recv_q    <= recv_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= SPI_rx_data;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (SPI_rx_valid && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign apb.PRDATA    = prdata_q;
    assign apb.PREADY_R  = pready_q;
    assign apb.PSLVERR_R = pslverr_q;
    assign SPI_recv      = recv_q;
    assign RX_level      = count_q;
    assign RX_overflow   = ovf_q;
endmodule

// File: tb/tb_apb_spi_read_handler.sv
// Scoreboard bench for apb_spi_read_handler: instance A uses the default timeout,
// instance B uses TIMEOUT=8 for the error-response path.
module tb_apb_spi_read_handler;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        io_reg = 1'b0, psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
    logic [15:0] rx_data_a = '0, rx_data_b = '0;
    logic        spi_recv_a, spi_recv_b, ovf_a_dut, ovf_b_dut;
    logic [2:0]  level_a, level_b;

    apb_spi_read_handler_if bus_a ();
    apb_spi_read_handler_if bus_b ();

    assign bus_a.IO_reg  = io_reg;
    assign bus_a.PSEL    = psel_a;
    assign bus_a.PENABLE = penable;
    assign bus_a.PWRITE  = pwrite;
    assign bus_b.IO_reg  = io_reg;
    assign bus_b.PSEL    = psel_b;
    assign bus_b.PENABLE = penable;
    assign bus_b.PWRITE  = pwrite;

    apb_spi_read_handler #(.DEPTH(DEPTH), .TIMEOUT(255)) dut_a (
        .PCLK(clk), .PRESET(rst), .apb(bus_a.slave),
        .SPI_rx_valid(rx_valid_a), .SPI_rx_data(rx_data_a),
        .SPI_recv(spi_recv_a), .RX_level(level_a), .RX_overflow(ovf_a_dut)
    );

    apb_spi_read_handler #(.DEPTH(DEPTH), .TIMEOUT(8)) dut_b (
        .PCLK(clk), .PRESET(rst), .apb(bus_b.slave),
        .SPI_rx_valid(rx_valid_b), .SPI_rx_data(rx_data_b),
        .SPI_recv(spi_recv_b), .RX_level(level_b), .RX_overflow(ovf_b_dut)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   recv_a = 0;
    int   recv_b = 0;
    int   lvl_a = 0;
    bit   ovf_a = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_recv_a === 1'b1) recv_a++;
        if (spi_recv_b === 1'b1) recv_b++;
    end

    // Every response is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (bus_a.PREADY_R === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb_a.size() == 0) begin
                n_fail++;
                $display("FAIL resp_a_unexpected: got PREADY_R=1 data=%h, required no response",
                         bus_a.PRDATA);
            end else begin
                e = sb_a.pop_front();
                if (!e.err) lvl_a--;
                if (bus_a.PRDATA !== e.data || bus_a.PSLVERR_R !== e.err) begin
                    n_fail++;
                    $display("FAIL resp_a: got data=%h err=%b, required data=%h err=%b",
                             bus_a.PRDATA, bus_a.PSLVERR_R, e.data, e.err);
                end
            end
        end
        if (bus_b.PREADY_R === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb_b.size() == 0) begin
                n_fail++;
                $display("FAIL resp_b_unexpected: got PREADY_R=1, required no response");
            end else begin
                e = sb_b.pop_front();
                if (bus_b.PRDATA !== e.data || bus_b.PSLVERR_R !== e.err) begin
                    n_fail++;
                    $display("FAIL resp_b: got data=%h err=%b, required data=%h err=%b",
                             bus_b.PRDATA, bus_b.PSLVERR_R, e.data, e.err);
                end
            end
        end
    end

    task automatic spi_push(input logic [15:0] d, output int c);
        @(posedge clk); #1;
        rx_valid_a = 1'b1;
        rx_data_a  = d;
        c = cyc;
        if (lvl_a < DEPTH) begin
            sb_a.push_back('{data: d, err: 1'b0});
            lvl_a++;
        end else begin
            ovf_a = 1'b1;
        end
        @(posedge clk); #1;
        rx_valid_a = 1'b0;
    endtask

    // Full APB read; optionally strobes an SPI word during the first access cycle.
    task automatic apb_read(input bit sel_b, input int budget, input bit strobe,
                            input logic [15:0] sdata, output bit got, output int rdy_cyc,
                            output int lat);
        logic r;
        @(posedge clk); #1;
        io_reg = 1'b1; pwrite = 1'b0; penable = 1'b0;
        if (sel_b) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        if (strobe) begin
            rx_valid_a = 1'b1;
            rx_data_a  = sdata;
        end
        got = 1'b0; rdy_cyc = 0; lat = 0;
        for (int i = 1; i <= budget && !got; i++) begin
            @(negedge clk);
            r = sel_b ? bus_b.PREADY_R : bus_a.PREADY_R;
            if (r === 1'b1) begin
                got = 1'b1; rdy_cyc = cyc; lat = i;
            end else begin
                @(posedge clk); #1;
                if (strobe) rx_valid_a = 1'b0;
            end
        end
        @(posedge clk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        if (strobe) rx_valid_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.PREADY_R, bus_a.PSLVERR_R, spi_recv_a, ovf_a_dut} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags_a: got %b, required 0000",
                     {bus_a.PREADY_R, bus_a.PSLVERR_R, spi_recv_a, ovf_a_dut});
        end
        n_checks++;
        if (bus_a.PRDATA !== 16'h0 || level_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_data_a: got data=%h level=%0d, required 0 and 0",
                     bus_a.PRDATA, level_a);
        end
        n_checks++;
        if (bus_b.PREADY_R !== 1'b0 || spi_recv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got ready=%b recv=%b, required 0 0",
                     bus_b.PREADY_R, spi_recv_b);
        end
    endtask

    task automatic test_fifo_read();
        bit got; int rc, lat, sc;
        spi_push(16'hA5A5, sc);
        @(negedge clk);
        n_checks++;
        if (level_a !== 3'd1) begin
            n_fail++; $display("FAIL t1_level_before: got %0d, required 1", level_a);
        end
        apb_read(1'b0, 6, 1'b0, 16'h0, got, rc, lat);
        n_checks++;
        if (!got || lat != 2) begin
            n_fail++; $display("FAIL t1_latency: got ready=%b lat=%0d, required 1 and 2", got, lat);
        end
        @(negedge clk);
        n_checks++;
        if (level_a !== 3'd0) begin
            n_fail++; $display("FAIL t1_level_after: got %0d, required 0", level_a);
        end
    endtask

    task automatic test_empty_wait();
        bit got; int rc, lat, sc, r0;
        r0 = recv_a;
        fork
            apb_read(1'b0, 40, 1'b0, 16'h0, got, rc, lat);
            begin
                repeat (12) @(posedge clk);
                spi_push(16'h1234, sc);
            end
        join
        n_checks++;
        if (!got || rc - sc != 2) begin
            n_fail++;
            $display("FAIL t2_latency: got ready=%b delay=%0d, required 1 and 2", got, rc - sc);
        end
        n_checks++;
        if (recv_a - r0 != 1) begin
            n_fail++; $display("FAIL t2_spi_recv: got %0d pulses, required 1", recv_a - r0);
        end
    endtask

    task automatic test_timeout();
        bit got; int rc, lat, r0;
        r0 = recv_b;
        sb_b.push_back('{data: 16'h0000, err: 1'b1});
        apb_read(1'b1, 20, 1'b0, 16'h0, got, rc, lat);
        n_checks++;
        if (!got || lat != 10) begin
            n_fail++; $display("FAIL t3_latency: got ready=%b lat=%0d, required 1 and 10", got, lat);
        end
        n_checks++;
        if (recv_b - r0 != 1) begin
            n_fail++; $display("FAIL t3_spi_recv: got %0d pulses, required 1", recv_b - r0);
        end
        @(negedge clk);
        n_checks++;
        if (bus_b.PREADY_R !== 1'b0 || bus_b.PSLVERR_R !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_release: got ready=%b err=%b, required 0 0",
                     bus_b.PREADY_R, bus_b.PSLVERR_R);
        end
    endtask

    task automatic test_overflow();
        bit got; int rc, lat, sc;
        for (int i = 1; i <= 5; i++) spi_push(16'(i), sc);
        @(negedge clk);
        n_checks++;
        if (level_a !== 3'(lvl_a) || ovf_a_dut !== ovf_a) begin
            n_fail++;
            $display("FAIL t4_full: got level=%0d ovf=%b, required %0d %b",
                     level_a, ovf_a_dut, lvl_a, ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            apb_read(1'b0, 6, 1'b0, 16'h0, got, rc, lat);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL t4_read%0d: got no response", i); end
        end
        @(negedge clk);
        n_checks++;
        if (level_a !== 3'd0 || ovf_a_dut !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_drained: got level=%0d ovf=%b, required 0 1", level_a, ovf_a_dut);
        end
    endtask

    task automatic test_reset_in_wait();
        bit got; int rc, lat, sc, r0;
        r0 = recv_a;
        @(posedge clk); #1;
        io_reg = 1'b1; pwrite = 1'b0; psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (recv_a - r0 != 1 || bus_a.PREADY_R !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_in_wait: got pulses=%0d ready=%b, required 1 0",
                     recv_a - r0, bus_a.PREADY_R);
        end
        @(posedge clk); #1;
        rst = 1'b1; psel_a = 1'b0; penable = 1'b0;
        lvl_a = 0; ovf_a = 1'b0; sb_a.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.PREADY_R, bus_a.PSLVERR_R, spi_recv_a, ovf_a_dut} !== 4'b0 ||
            bus_a.PRDATA !== 16'h0 || level_a !== 3'd0) begin
            n_fail++;
            $display("FAIL t5_after_reset: got flags=%b data=%h level=%0d, required 0",
                     {bus_a.PREADY_R, bus_a.PSLVERR_R, spi_recv_a, ovf_a_dut},
                     bus_a.PRDATA, level_a);
        end
        r0 = recv_a;
        fork
            apb_read(1'b0, 30, 1'b0, 16'h0, got, rc, lat);
            begin
                repeat (6) @(posedge clk);
                spi_push(16'hBEEF, sc);
            end
        join
        n_checks++;
        if (!got || recv_a - r0 != 1) begin
            n_fail++;
            $display("FAIL t5_fresh_read: got ready=%b pulses=%0d, required 1 1", got, recv_a - r0);
        end
    endtask

    task automatic test_full_push_pop();
        bit got; int rc, lat, sc;
        for (int i = 0; i < 4; i++) spi_push(16'h0010 + 16'(i), sc);
        // Coincident strobe: model sees one push and one pop, so level nets to 4.
        sb_a.push_back('{data: 16'h0014, err: 1'b0});
        lvl_a++;
        apb_read(1'b0, 6, 1'b1, 16'h0014, got, rc, lat);
        @(negedge clk);
        n_checks++;
        if (!got || level_a !== 3'd4 || ovf_a_dut !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_push_pop: got ready=%b level=%0d ovf=%b, required 1 4 0",
                     got, level_a, ovf_a_dut);
        end
        for (int i = 0; i < 4; i++) begin
            apb_read(1'b0, 6, 1'b0, 16'h0, got, rc, lat);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL t6_read%0d: got no response", i); end
        end
    endtask

    task automatic test_ignored_access();
        bit got; int rc, lat, sc, r0;
        spi_push(16'h5A5A, sc);
        r0 = recv_a;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            psel_a = 1'b1;
            io_reg = (k == 1) ? 1'b0 : 1'b1;
            pwrite = (k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            penable = 1'b1;
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
            psel_a = 1'b0; penable = 1'b0; pwrite = 1'b0;
            @(negedge clk);
            n_checks++;
            if (level_a !== 3'd1 || recv_a != r0) begin
                n_fail++;
                $display("FAIL t7_ignored%0d: got level=%0d pulses=%0d, required 1 0",
                         k, level_a, recv_a - r0);
            end
        end
        apb_read(1'b0, 6, 1'b0, 16'h0, got, rc, lat);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL t7_read: got no response"); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fifo_read();
        test_empty_wait();
        test_timeout();
        test_overflow();
        test_reset_in_wait();
        test_full_push_pop();
        test_ignored_access();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0",
                     sb_a.size(), sb_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
